// File: rtl/isp_oecf_pkg.sv
// rtl/isp_oecf_pkg.sv - shared FSM state, table-select constants and command entry type for the OECF LUT controller
package isp_oecf_pkg;

    // Entry fields are sized for the widest supported LUT; narrower builds zero-extend.
    localparam int OECF_MAX_BITS = 16;

    localparam logic [1:0] TBL_R  = 2'd0;
    localparam logic [1:0] TBL_GR = 2'd1;
    localparam logic [1:0] TBL_GB = 2'd2;
    localparam logic [1:0] TBL_B  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GATE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE,
        ST_RESP
    } oecf_state_t;

    typedef struct packed {
        logic                     write;
        logic [1:0]               sel;
        logic [OECF_MAX_BITS-1:0] addr;
        logic [OECF_MAX_BITS-1:0] wdata;
    } oecf_cmd_t;

    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        case (sel)
            TBL_R:   return 4'b0001;
            TBL_GR:  return 4'b0010;
            TBL_GB:  return 4'b0100;
            TBL_B:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/isp_oecf_cmd_fifo.sv
// rtl/isp_oecf_cmd_fifo.sv - synchronous command FIFO with full/empty flags
module isp_oecf_cmd_fifo
    import isp_oecf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      pclk,
    input  logic      rst,
    input  logic      i_push,
    input  oecf_cmd_t i_data,
    input  logic      i_pop,
    output oecf_cmd_t o_data,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH;

    oecf_cmd_t     r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A full FIFO never accepts, even when a pop frees a slot in the same cycle.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/isp_oecf_lut_ctrl.sv
// rtl/isp_oecf_lut_ctrl.sv - OECF LUT host access sequencer; write gating to vsync blanking under ISP_OECF_LUT_CTRL_VSYNC_GATE_EN
module isp_oecf_lut_ctrl
    import isp_oecf_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              in_vsync,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [1:0]        cmd_sel,
    input  logic [BITS-1:0]   cmd_addr,
    input  logic [BITS-1:0]   cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BITS-1:0]   rsp_rdata,
    output logic [3:0]        tbl_wen,
    output logic [3:0]        tbl_ren,
    output logic [BITS-1:0]   tbl_addr,
    output logic [BITS-1:0]   tbl_wdata,
    input  logic [4*BITS-1:0] tbl_rdata,
    output logic              busy
);
    oecf_state_t     r_state;
    oecf_state_t     w_next;
    oecf_cmd_t       r_cmd;
    logic [BITS-1:0] r_rdata;
    oecf_cmd_t       w_push_data;
    oecf_cmd_t       w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_gate_hold;

`ifdef ISP_OECF_LUT_CTRL_VSYNC_GATE_EN
    assign w_gate_hold = !in_vsync;
`else
    logic w_unused_vsync;
    assign w_gate_hold    = 1'b0;
    assign w_unused_vsync = in_vsync;
`endif

    assign cmd_ready   = !w_full && !rst;
    assign w_push      = cmd_valid && cmd_ready;
    assign w_push_data = '{write: cmd_write, sel: cmd_sel,
                           addr: OECF_MAX_BITS'(cmd_addr), wdata: OECF_MAX_BITS'(cmd_wdata)};

    isp_oecf_cmd_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .pclk    (pclk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    if (!w_head.write) begin
                        w_next = ST_READ;
                    end else if (w_gate_hold) begin
                        w_next = ST_GATE;
                    end else begin
                        w_next = ST_WRITE;
                    end
                end
            end
`ifdef ISP_OECF_LUT_CTRL_VSYNC_GATE_EN
            ST_GATE:    if (in_vsync) w_next = ST_WRITE;
`endif
            ST_WRITE:   w_next = ST_IDLE;
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_RESP;
            ST_RESP:    if (rsp_ready) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        tbl_wen   = 4'b0000;
        tbl_ren   = 4'b0000;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE:  w_pop     = !w_empty;
            ST_WRITE: tbl_wen   = sel_onehot(r_cmd.sel);
            ST_READ:  tbl_ren   = sel_onehot(r_cmd.sel);
            ST_RESP:  rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    // The popped entry is held until the next pop, so the table bus keeps its last values when idle.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_cmd   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_pop) begin
                r_cmd <= w_head;
            end
            if (r_state == ST_CAPTURE) begin
                r_rdata <= tbl_rdata[int'(r_cmd.sel) * BITS +: BITS];
            end
        end
    end

    assign tbl_addr  = BITS'(r_cmd.addr);
    assign tbl_wdata = BITS'(r_cmd.wdata);
    assign rsp_rdata = r_rdata;
    assign busy      = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_isp_oecf_lut_ctrl.sv
// tb/tb_isp_oecf_lut_ctrl.sv - directed bench with an in-order table/scoreboard model for isp_oecf_lut_ctrl
module tb_isp_oecf_lut_ctrl;
    import isp_oecf_pkg::*;

    logic        pclk = 1'b0;
    logic        rst;
    logic        in_vsync;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_sel;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic [3:0]  tbl_wen;
    logic [3:0]  tbl_ren;
    logic [7:0]  tbl_addr;
    logic [7:0]  tbl_wdata;
    logic [31:0] tbl_rdata;
    logic        busy;

    isp_oecf_lut_ctrl #(.BITS(8), .DEPTH(4)) dut (
        .pclk      (pclk),
        .rst       (rst),
        .in_vsync  (in_vsync),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_sel   (cmd_sel),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .tbl_wen   (tbl_wen),
        .tbl_ren   (tbl_ren),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .tbl_rdata (tbl_rdata),
        .busy      (busy)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit       w;
        bit [1:0] s;
        bit [7:0] a;
        bit [7:0] d;
    } cmd_t;

    int       n_vec = 0;
    int       n_err = 0;
    bit [7:0] tbl_mem [4][256];
    cmd_t     exp_q[$];
    bit [7:0] rsp_q[$];
    bit [7:0] rsp_log[$];
    cmd_t     e;
    bit [7:0] rsp_cur;
    bit       rsp_active = 1'b0;
    bit       ren_seen = 1'b0;
    bit [7:0] ren_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got no event, expected one within bound", name);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Model: every accepted command must produce exactly one strobe, in order; reads yield the table value at strobe time.
    always @(negedge pclk) begin
        ren_seen = |tbl_ren;
        ren_addr = tbl_addr;
        if (!rst) begin
            if ((tbl_wen | tbl_ren) != 4'b0000) begin
                check("strobe_onehot", $countones({tbl_wen, tbl_ren}), 1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got wen=%b ren=%b, expected none", tbl_wen, tbl_ren);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_bits", {tbl_wen, tbl_ren},
                          e.w ? {4'b0001 << e.s, 4'b0000} : {4'b0000, 4'b0001 << e.s});
                    check("strobe_addr", tbl_addr, e.a);
                    if (e.w) begin
                        check("strobe_wdata", tbl_wdata, e.d);
                        tbl_mem[e.s][e.a] = e.d;
                    end else begin
                        rsp_q.push_back(tbl_mem[e.s][e.a]);
                    end
                end
            end
            if (rsp_valid) begin
                if (!rsp_active) begin
                    if (rsp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0");
                    end else begin
                        rsp_cur = rsp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, rsp_cur);
                        rsp_log.push_back(rsp_rdata);
                    end
                    rsp_active = 1'b1;
                end else begin
                    check("rsp_stable", rsp_rdata, rsp_cur);
                end
                if (rsp_ready) rsp_active = 1'b0;
            end else if (rsp_active) begin
                check("rsp_held", rsp_valid, 1);
                rsp_active = 1'b0;
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{cmd_write, cmd_sel, cmd_addr, cmd_wdata});
            end
        end
    end

    always @(posedge pclk) begin
        if (rst) begin
            exp_q.delete();
            rsp_q.delete();
            rsp_active = 1'b0;
        end
    end

    // Table model: read data valid only in the cycle after a ren strobe, noise otherwise.
    always @(posedge pclk) begin
        #1;
        if (ren_seen) begin
            tbl_rdata = {tbl_mem[3][ren_addr], tbl_mem[2][ren_addr], tbl_mem[1][ren_addr], tbl_mem[0][ren_addr]};
        end else begin
            tbl_rdata = $urandom;
        end
    end

    task automatic push(input bit w, input bit [1:0] s, input bit [7:0] a, input bit [7:0] d);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_sel   = s;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge pclk);
        while (!cmd_ready && k < 100) begin
            tick();
            @(negedge pclk);
            k++;
        end
        if (!cmd_ready) fail("push_timeout");
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_for_rsp();
        int k = 0;
        @(negedge pclk);
        while (!rsp_valid && k < 50) begin
            tick();
            @(negedge pclk);
            k++;
        end
        if (!rsp_valid) fail("rsp_timeout");
        tick();
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge pclk);
        while (busy && k < 200) begin
            tick();
            @(negedge pclk);
            k++;
        end
        if (busy) fail("idle_timeout");
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int k;
        int nw;
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < 256; a++) tbl_mem[t][a] = 8'($urandom);
        end
        rst       = 1'b1;
        in_vsync  = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_sel   = 2'd0;
        cmd_addr  = 8'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        tbl_rdata = 32'h0;

        tick();
        tick();
        @(negedge pclk);
        check("rst_cmd_ready_low", cmd_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_strobes", {tbl_wen, tbl_ren}, 0);
        check("rst_addr", tbl_addr, 0);
        check("rst_wdata", tbl_wdata, 0);

        // Ungated write: strobe only in cycle 2.
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = TBL_GB; cmd_addr = 8'h10; cmd_wdata = 8'hA5;
        for (int c = 0; c < 5; c++) begin
            @(negedge pclk);
            check("w1_wen", tbl_wen, (c == 2) ? 4'b0100 : 4'b0000);
            if (c == 2) begin
                check("w1_addr", tbl_addr, 8'h10);
                check("w1_wdata", tbl_wdata, 8'hA5);
            end
            tick();
            cmd_valid = 1'b0;
        end
        check("w1_hold_addr", tbl_addr, 8'h10);

        // Read with a 5-cycle response stall.
        tbl_mem[3][8'h7F] = 8'h3C;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_sel = TBL_B; cmd_addr = 8'h7F; cmd_wdata = 8'h00;
        for (int c = 0; c < 11; c++) begin
            @(negedge pclk);
            check("r1_ren", tbl_ren, (c == 2) ? 4'b1000 : 4'b0000);
            check("r1_rsp_valid", rsp_valid, (c >= 4 && c <= 9) ? 1 : 0);
            if (c >= 4 && c <= 9) check("r1_rsp_rdata", rsp_rdata, 8'h3C);
            tick();
            cmd_valid = 1'b0;
            if (c == 8) rsp_ready = 1'b1;
        end

`ifdef ISP_OECF_LUT_CTRL_VSYNC_GATE_EN
        in_vsync = 1'b0;
        push(1'b1, TBL_GR, 8'h22, 8'h5A);
        nw = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge pclk);
            if (tbl_wen != 4'b0000) nw++;
            tick();
        end
        check("gate_no_wen", nw, 0);
        @(negedge pclk);
        check("gate_busy", busy, 1);
        tick();
        in_vsync = 1'b1;
        nw = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            if (tbl_wen != 4'b0000) nw++;
            tick();
            in_vsync = 1'b0;
        end
        check("gate_one_wen", nw, 1);
        in_vsync = 1'b1;
`else
        in_vsync = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = TBL_GR; cmd_addr = 8'h33; cmd_wdata = 8'h44;
        for (int c = 0; c < 4; c++) begin
            @(negedge pclk);
            check("nogate_wen", tbl_wen, (c == 2) ? 4'b0010 : 4'b0000);
            tick();
            cmd_valid = 1'b0;
        end
        in_vsync = 1'b1;
`endif
        wait_idle();

        // Fill the FIFO while a response is stalled.
        rsp_ready = 1'b0;
        push(1'b0, TBL_R, 8'h05, 8'h00);
        wait_for_rsp();
        push(1'b1, TBL_R, 8'h01, 8'h11);
        push(1'b0, TBL_R, 8'h01, 8'h00);
        push(1'b1, TBL_GR, 8'h02, 8'h22);
        push(1'b0, TBL_GR, 8'h02, 8'h00);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = TBL_B; cmd_addr = 8'h03; cmd_wdata = 8'h33;
        @(negedge pclk);
        check("full_cmd_ready", cmd_ready, 0);
        check("full_busy", busy, 1);
        tick();
        rsp_ready = 1'b1;
        k = 0;
        @(negedge pclk);
        while (!cmd_ready && k < 20) begin
            tick();
            @(negedge pclk);
            k++;
        end
        if (!cmd_ready) fail("full_drain");
        tick();
        cmd_valid = 1'b0;
        wait_idle();
        check("fifo_rd1", rsp_log[rsp_log.size() - 2], 8'h11);
        check("fifo_rd2", rsp_log[rsp_log.size() - 1], 8'h22);
        check("fifo_wr_b", tbl_mem[3][8'h03], 8'h33);

        // Reset in the cycle a read strobe is high, with two commands queued.
        rsp_ready = 1'b0;
        push(1'b0, TBL_GB, 8'h40, 8'h00);
        wait_for_rsp();
        push(1'b0, TBL_R, 8'h41, 8'h00);
        push(1'b1, TBL_GR, 8'h42, 8'h77);
        push(1'b1, TBL_B, 8'h43, 8'h88);
        rsp_ready = 1'b1;
        k = 0;
        @(negedge pclk);
        while (tbl_ren == 4'b0000 && k < 20) begin
            tick();
            @(negedge pclk);
            k++;
        end
        if (tbl_ren == 4'b0000) fail("rst_ren_timeout");
        check("rst_mid_ren", tbl_ren, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge pclk);
        check("rst_mid_strobes", {tbl_wen, tbl_ren}, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_rsp_rdata", rsp_rdata, 0);
        check("rst_mid_addr", tbl_addr, 0);
        check("rst_mid_wdata", tbl_wdata, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        tick();
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge pclk);
            if ((tbl_wen | tbl_ren) != 4'b0000 || rsp_valid) nw++;
            tick();
        end
        check("rst_mid_quiet", nw, 0);
        check("rst_mid_busy_after", busy, 0);

        check("end_exp_q", exp_q.size(), 0);
        check("end_rsp_q", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/isp_oecf_lut_ctrl.md
ISP_OECF_LUT_CTRL -- requirements
Module: isp_oecf_lut_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8: LUT data and address width; each table holds 2**BITS entries.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO depth, a power of two and at least 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset:
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous active-high reset.
REQ-004 SHALL have the following ports:
- in_vsync  in  1  frame-blank indicator from ISP timing.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_sel  in  2  table select: 0 R, 1 GR, 2 GB, 3 B.
- cmd_addr  in  BITS  LUT address.
- cmd_wdata  in  BITS  write data.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_rdata  out  BITS  read data.
- tbl_wen  out  4  one-hot write strobe; bit i = table i.
- tbl_ren  out  4  one-hot read strobe.
- tbl_addr  out  BITS  shared table address.
- tbl_wdata  out  BITS  shared table write data.
- tbl_rdata  in  4*BITS  table read data; slice i = table i; valid one cycle after the ren strobe.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Function
REQ-005 SHALL accept a command on the pclk edge where cmd_valid && cmd_ready, pushing {write, sel, addr, wdata} into the FIFO.
REQ-006 SHALL drive cmd_ready = !fifo_full; there is no push while full, even if a pop occurs in the same cycle.
REQ-007 SHALL execute commands strictly in order, one at a time, using the FSM states IDLE, GATE, WRITE, READ, CAPTURE, RESP.
REQ-008 SHALL, in IDLE with the FIFO non-empty, pop the head entry and transition as follows:
- write entry, gating active and in_vsync=0 -> GATE;
- other write entry -> WRITE;
- read entry -> READ.
REQ-009 SHALL remain in GATE until in_vsync is sampled 1, then go to WRITE.
REQ-010 SHALL, in WRITE, assert tbl_wen[sel] for exactly one cycle with tbl_addr/tbl_wdata from the entry, then return to IDLE.
REQ-011 SHALL, in READ, assert tbl_ren[sel] for exactly one cycle, then go to CAPTURE.
REQ-012 SHALL, in CAPTURE, register tbl_rdata slice [sel] into rsp_rdata, then go to RESP.
REQ-013 SHALL, in RESP, hold rsp_valid=1 and rsp_rdata stable until rsp_ready=1, then return to IDLE.
REQ-014 SHALL never apply gating to reads.
REQ-015 SHALL meet this latency with gating inactive and an empty, idle block:
- command accepted in cycle 0 -> strobe in cycle 2;
- read -> rsp_valid first high in cycle 4.
REQ-016 SHALL drive tbl_wen/tbl_ren to zero outside WRITE/READ; at most one strobe bit is ever high.
REQ-017 SHALL hold tbl_addr/tbl_wdata at their last values when idle.
REQ-018 SHALL keep accepting commands while in GATE or RESP, up to DEPTH entries.
REQ-019 SHALL keep in_vsync falling after GATE exits from cancelling a write already in WRITE.

Reset
REQ-020 SHALL, on rst=1 at a pclk edge:
- flush the FIFO and set the FSM to IDLE;
- drive cmd_ready=0 during reset, and 1 on the first cycle after reset;
- drive rsp_valid=0, rsp_rdata=0, tbl_wen=0, tbl_ren=0, tbl_addr=0, tbl_wdata=0, busy=0.
REQ-021 SHALL, on reset mid-operation, drop any pending or in-flight command, including an unacknowledged response, with no strobe issued after reset.

Configuration
REQ-022 SHALL compile write gating only when macro ISP_OECF_LUT_CTRL_VSYNC_GATE_EN is defined: writes execute only after in_vsync is sampled 1 (REQ-008/009).
REQ-023 SHALL, without ISP_OECF_LUT_CTRL_VSYNC_GATE_EN, omit the GATE state and ignore in_vsync for all commands.

Structure
REQ-024 SHALL take the following from shared package isp_oecf_pkg:
- the FSM state enum;
- table-select constants TBL_R=0, TBL_GR=1, TBL_GB=2, TBL_B=3;
- the FIFO entry struct type.
REQ-025 SHALL implement the command FIFO as sub-module isp_oecf_cmd_fifo (synchronous, registered, with full/empty flags).

Verification
REQ-026 SHALL cover these directed scenarios:
- Ungated write sel=2, addr=0x10, data=0xA5 accepted in cycle 0 -> tbl_wen=4'b0100, tbl_addr=0x10, tbl_wdata=0xA5 in cycle 2 only.
- Read sel=3, addr=0x7F, table model returns 0x3C -> tbl_ren=4'b1000 in cycle 2; rsp_valid=1, rsp_rdata=0x3C from cycle 4; rsp_ready held 0 for 5 cycles -> response stable, then clears one cycle after rsp_ready.
- Gated build, in_vsync=0, write issued -> no tbl_wen for 50 cycles, busy=1; raise in_vsync -> exactly one wen pulse within 2 cycles.
- Push 5 commands back-to-back with DEPTH=4 while in RESP -> cmd_ready=0 after the 4th, with all 5 executed in order.
- Assert rst in the cycle tbl_ren is high, with 2 commands queued -> next cycle all outputs are 0, no later strobes, busy=0.
